// File: rtl/ascon_pack.sv
// ascon_pack: shared constants and types for the Ascon-128 tag path
package ascon_pack;
  localparam int TAG_W = 128;
  typedef logic [TAG_W-1:0] tag_t;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_CT,
    ST_COMPARE,
    ST_DONE
  } tag_verify_state_t;
endpackage

// File: rtl/tag_word_reg.sv
// tag_word_reg: TAG_W register with per-word write enables and a synchronous clear
module tag_word_reg
  import ascon_pack::*;
#(
  parameter int WORD_W = 32,
  localparam int NB_WORDS = TAG_W / WORD_W
) (
  input  logic                clock_i,
  input  logic                resetb_i,
  input  logic                i_clr,
  input  logic [NB_WORDS-1:0] i_we,
  input  tag_t                i_d,
  output tag_t                o_q
);
  tag_t r_q;
  // word k (k=0 is the MS word) is written from the same word position of i_d
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) r_q <= '0;
    else if (i_clr) r_q <= '0;
    else
      for (int k = 0; k < NB_WORDS; k++)
        if (i_we[k]) r_q[TAG_W-1-k*WORD_W -: WORD_W] <= i_d[TAG_W-1-k*WORD_W -: WORD_W];
  end
  assign o_q = r_q;
endmodule

// File: rtl/ascon_tag_verify.sv
// ascon_tag_verify: constant-time comparison of received and computed Ascon-128 tags
module ascon_tag_verify
  import ascon_pack::*;
#(
  parameter int WORD_W = 32,
  localparam int NB_WORDS = TAG_W / WORD_W
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] tag_word_i,
  input  logic              tag_valid_i,
  output logic              tag_ready_o,
  input  tag_t              computed_tag_i,
  input  logic              computed_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              tag_ok_o
);
  localparam int CW = NB_WORDS > 1 ? $clog2(NB_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB_WORDS - 1);

  tag_verify_state_t r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic              r_have_ct, r_done, r_ok;
  logic [WORD_W-1:0] r_acc, w_exp_word, w_ct_word;
  logic              w_accept, w_ct_cap, w_last;
  logic [NB_WORDS-1:0] w_exp_we, w_ct_we;
  tag_t              w_exp, w_ct;

  assign tag_ready_o = r_state == ST_LOAD;
  assign busy_o      = r_state inside {ST_LOAD, ST_WAIT_CT, ST_COMPARE};
  assign done_o      = r_done;
  assign tag_ok_o    = r_ok;
  // start has priority: a word or tag presented on the start edge is dropped
  assign w_accept    = tag_ready_o && tag_valid_i && !start_i;
  assign w_ct_cap    = computed_valid_i && !start_i && (r_state inside {ST_LOAD, ST_WAIT_CT});
  assign w_last      = w_accept && r_cnt == LAST;
  assign w_exp_we    = {NB_WORDS{w_accept}} & (NB_WORDS'(1) << r_cnt);
  assign w_ct_we     = {NB_WORDS{w_ct_cap}};
  assign w_exp_word  = w_exp[TAG_W-1-WORD_W*int'(r_cnt) -: WORD_W];
  assign w_ct_word   = w_ct[TAG_W-1-WORD_W*int'(r_cnt) -: WORD_W];

  tag_word_reg #(.WORD_W(WORD_W)) u_exp_reg (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .i_clr   (start_i),
    .i_we    (w_exp_we),
    .i_d     ({NB_WORDS{tag_word_i}}),
    .o_q     (w_exp)
  );

  tag_word_reg #(.WORD_W(WORD_W)) u_ct_reg (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .i_clr   (start_i),
    .i_we    (w_ct_we),
    .i_d     (computed_tag_i),
    .o_q     (w_ct)
  );

  // state register
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) r_state <= ST_IDLE;
    else r_state <= w_next;
  end

  // next-state logic; start restarts from any state
  always_comb begin
    w_next = r_state;
    if (start_i) w_next = ST_LOAD;
    else
      unique case (r_state)
        ST_LOAD:    if (w_last) w_next = (r_have_ct || computed_valid_i) ? ST_COMPARE : ST_WAIT_CT;
        ST_WAIT_CT: if (computed_valid_i) w_next = ST_COMPARE;
        ST_COMPARE: if (r_cnt == LAST) w_next = ST_DONE;
        ST_DONE:    w_next = ST_DONE;
        default:    w_next = ST_IDLE;
      endcase
  end

  // counter, computed-tag flag, OR-accumulated difference and registered result
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_cnt     <= '0;
      r_have_ct <= 1'b0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
    end else if (start_i) begin
      r_cnt     <= '0;
      r_have_ct <= 1'b0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
    end else begin
      if (w_accept || r_state == ST_COMPARE) r_cnt <= r_cnt == LAST ? '0 : r_cnt + 1'b1;
      if (w_ct_cap) r_have_ct <= 1'b1;
      if (r_state == ST_COMPARE) r_acc <= r_acc | (w_exp_word ^ w_ct_word);
      r_done <= r_state == ST_DONE;
      r_ok   <= r_state == ST_DONE && r_acc == '0;
    end
  end
endmodule

// File: tb/tb_ascon_tag_verify.sv
// tb_ascon_tag_verify: directed vectors for the tag verification block
module tb_ascon_tag_verify;
  logic         clock_i = 0;
  logic         resetb_i = 0;
  logic         start_i = 0;
  logic [31:0]  tag_word_i = '0;
  logic         tag_valid_i = 0;
  logic         tag_ready_o;
  logic [127:0] computed_tag_i = '0;
  logic         computed_valid_i = 0;
  logic         busy_o, done_o, tag_ok_o;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] GOOD = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] BAD  = 128'h0123456789ABCDEFFEDCBA9876543211;
  logic [31:0] words [4] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};

  ascon_tag_verify #(.WORD_W(32)) dut (
    .clock_i         (clock_i),
    .resetb_i        (resetb_i),
    .start_i         (start_i),
    .tag_word_i      (tag_word_i),
    .tag_valid_i     (tag_valid_i),
    .tag_ready_o     (tag_ready_o),
    .computed_tag_i  (computed_tag_i),
    .computed_valid_i(computed_valid_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .tag_ok_o        (tag_ok_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic do_start;
    start_i = 1;
    tick;
    start_i = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic ct_too, input logic [127:0] ct);
    tag_word_i = w;
    tag_valid_i = 1;
    if (ct_too) begin
      computed_tag_i = ct;
      computed_valid_i = 1;
    end
    tick;
    tag_valid_i = 0;
    computed_valid_i = 0;
  endtask

  task automatic ct_pulse(input logic [127:0] ct);
    computed_tag_i = ct;
    computed_valid_i = 1;
    tick;
    computed_valid_i = 0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (!done_o && n < 20) begin
      tick;
      n++;
    end
    check(tag, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    #12;
    check("reset_done", {31'b0, done_o}, 0);
    check("reset_ok", {31'b0, tag_ok_o}, 0);
    check("reset_busy", {31'b0, busy_o}, 0);
    check("reset_ready", {31'b0, tag_ready_o}, 0);
    resetb_i = 1;
    tick;
    // computed tag pulse in IDLE without start is ignored
    ct_pulse('0);
    repeat (3) tick;
    check("idle_busy", {31'b0, busy_o}, 0);
    check("idle_done", {31'b0, done_o}, 0);
    // match: tag arrives after the last word, via WAIT_CT
    do_start;
    check("load_busy", {31'b0, busy_o}, 1);
    check("load_ready", {31'b0, tag_ready_o}, 1);
    for (int i = 0; i < 4; i++) send_word(words[i], 0, '0);
    check("wait_ready", {31'b0, tag_ready_o}, 0);
    check("wait_busy", {31'b0, busy_o}, 1);
    repeat (3) tick;
    check("wait_hold_done", {31'b0, done_o}, 0);
    ct_pulse(GOOD);
    check("cmp_ok_low", {31'b0, tag_ok_o}, 0);
    wait_done("match_latency", 5);
    check("match_ok", {31'b0, tag_ok_o}, 1);
    check("match_busy", {31'b0, busy_o}, 0);
    repeat (4) tick;
    check("done_hold", {31'b0, done_o}, 1);
    // single-bit mismatch, identical latency
    do_start;
    check("restart_done", {31'b0, done_o}, 0);
    for (int i = 0; i < 4; i++) send_word(words[i], 0, '0);
    ct_pulse(BAD);
    wait_done("mismatch_latency", 5);
    check("mismatch_ok", {31'b0, tag_ok_o}, 0);
    // computed tag first, valid toggling
    do_start;
    ct_pulse(GOOD);
    check("ct_first_ready", {31'b0, tag_ready_o}, 1);
    for (int i = 0; i < 4; i++) begin
      send_word(words[i], 0, '0);
      if (i < 3) begin
        tag_word_i = 32'hDEADBEEF;
        tick;
        check("toggle_ready", {31'b0, tag_ready_o}, 1);
      end
    end
    wait_done("ct_first_latency", 5);
    check("ct_first_ok", {31'b0, tag_ok_o}, 1);
    // computed tag on the same edge as the last word
    do_start;
    for (int i = 0; i < 3; i++) send_word(words[i], 0, '0);
    send_word(words[3], 1, GOOD);
    wait_done("same_edge_latency", 5);
    check("same_edge_ok", {31'b0, tag_ok_o}, 1);
    // abort after two stale words
    do_start;
    send_word(32'hCAFEF00D, 0, '0);
    send_word(32'h0BADC0DE, 0, '0);
    do_start;
    check("abort_done", {31'b0, done_o}, 0);
    check("abort_ready", {31'b0, tag_ready_o}, 1);
    for (int i = 0; i < 3; i++) send_word(words[i], 0, '0);
    send_word(words[3], 1, GOOD);
    wait_done("abort_latency", 5);
    check("abort_ok", {31'b0, tag_ok_o}, 1);
    // start with a word on the same edge: word dropped, tag then differs
    tag_word_i = 32'h01234567;
    tag_valid_i = 1;
    start_i = 1;
    tick;
    start_i = 0;
    tag_valid_i = 0;
    for (int i = 1; i < 4; i++) send_word(words[i], 0, '0);
    check("start_wins_ready", {31'b0, tag_ready_o}, 1);
    send_word(32'h00000000, 1, GOOD);
    wait_done("start_wins_latency", 5);
    check("start_wins_ok", {31'b0, tag_ok_o}, 0);
    // asynchronous reset during compare cycle 2
    do_start;
    for (int i = 0; i < 3; i++) send_word(words[i], 0, '0);
    send_word(words[3], 1, GOOD);
    tick;
    tick;
    resetb_i = 0;
    #1;
    check("rst_busy", {31'b0, busy_o}, 0);
    check("rst_done", {31'b0, done_o}, 0);
    check("rst_ok", {31'b0, tag_ok_o}, 0);
    check("rst_ready", {31'b0, tag_ready_o}, 0);
    #3;
    resetb_i = 1;
    tick;
    check("post_rst_busy", {31'b0, busy_o}, 0);
    // all-zero words, no computed tag: parks in WAIT_CT
    do_start;
    for (int i = 0; i < 4; i++) send_word('0, 0, '0);
    repeat (10) tick;
    check("park_done", {31'b0, done_o}, 0);
    check("park_busy", {31'b0, busy_o}, 1);
    check("park_ready", {31'b0, tag_ready_o}, 0);
    ct_pulse('0);
    wait_done("zero_latency", 5);
    check("zero_ok", {31'b0, tag_ok_o}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
